// File: rtl/inst_axi_rd_bridge.sv
// rtl/inst_axi_rd_bridge.sv - fetch-stage SRAM-like request port to single-beat AXI4 read bridge
module inst_axi_rd_bridge #(
    parameter int         MAX_OUTST = 2,
    parameter logic [3:0] ARID_VAL  = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_err_q, rd_err_d;
    logic        addr_ok;
    logic        r_fire;

    // Write-side and AXI sideband inputs have no role in a read-only in-order bridge.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    assign addr_ok = (state_q == AR_IDLE) && inst_sram_req && !inst_sram_wr
                     && (cnt_q < 2'(MAX_OUTST));
    assign rready  = (cnt_q != 2'd0);
    assign r_fire  = rvalid && rready;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arsize_d = arsize_q;
        case (state_q)
            AR_IDLE: begin
                if (addr_ok) begin
                    araddr_d = inst_sram_addr;
                    arsize_d = {1'b0, inst_sram_size};
                    state_d  = AR_WAIT;
                end
            end
            default: begin
                if (arready) begin
                    state_d = AR_IDLE;
                end
            end
        endcase
    end

    // Acceptance and completion in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({addr_ok, r_fire})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign rd_err_d = r_fire && (rresp != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= AR_IDLE;
            araddr_q <= 32'd0;
            arsize_q <= 3'd0;
            cnt_q    <= 2'd0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arsize_q <= arsize_d;
            cnt_q    <= cnt_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = r_fire;
    assign inst_sram_rdata   = rdata;
    assign arid              = ARID_VAL;
    assign araddr            = araddr_q;
    assign arlen             = 8'd0;
    assign arsize            = arsize_q;
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'd0;
    assign arprot            = 3'd0;
    assign arvalid           = (state_q == AR_WAIT);
    assign rd_err            = rd_err_q;

endmodule
